multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control unit for the RV32I datapath. It fetches through a ready-handshaked memory port and latches the instruction. It then sequences IF/ID/EX/MEM/WB, driving every datapath select, write-enable and the 4-bit `aluctr` code consumed by the ALU control decoder. It sits between the instruction/data memory interface and the shared ALU/regfile datapath.

## Interface
No parameters (RV32I, 32-bit fixed).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: instruction memory read data, valid when `mem_ready` is high during IF.
- `mem_ready` in 1: memory handshake; sampled only while `imem_req` or `dmem_req` is high.
- `zero`, `less` in 1 each: ALU flags, used in EX of branches.
- `imem_req`, `dmem_req`, `dmem_we` out 1 each: memory requests.
- `ir_we` out 1: 1-cycle pulse on instruction capture.
- `pc_we` out 1; `pc_src` out 2: 00 = pc+4, 01 = pc+imm, 10 = (rs1+imm)&~1.
- `reg_we` out 1; `wb_sel` out 2: 00 = ALU, 01 = mem, 10 = pc+4.
- `alua_src` out 2: 00 = rs1, 01 = pc, 10 = 0.
- `alub_src` out 2: 00 = rs2, 01 = imm.
- `ext_op` out 3: 000 = I, 001 = U, 010 = S, 011 = B, 100 = J.
- `aluctr` out 4: 0000 add, 1000 sub, 0001 sll, 0010 slt, 0011 sltu, 0100 xor, 0101 srl, 1101 sra, 0110 or, 0111 and.
- `illegal` out 1; `state` out 3: debug.

## Operation
- States: IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALT=6. Internal IR register.
- Outputs are combinational from the registered state and IR. All outputs not listed for a state are 0.
- IDLE → IF unconditionally.
- IF: `imem_req`=1. On `mem_ready`: `ir_we`=1, IR←`instr`, → ID. Otherwise stay in IF.
- ID: decode IR. If illegal → HALT, else → EX.
- EX: `aluctr`, `alua_src`, `alub_src` and `ext_op` are valid.
  - Branch: `pc_we`=1, `pc_src`=taken?01:00, → IF.
  - Load/store → MEM. All other instructions → WB.
- MEM: `dmem_req`=1, and `dmem_we`=1 for stores. Hold until `mem_ready`.
  - Load → WB.
  - Store: `pc_we`=1, `pc_src`=00 in the `mem_ready` cycle, → IF.
- WB: `reg_we`=1, `pc_we`=1, → IF.
  - OP/OP-IMM/LUI/AUIPC: `wb_sel`=00, `pc_src`=00.
  - Load: `wb_sel`=01, `pc_src`=00.
  - JAL: `wb_sel`=10, `pc_src`=01. JALR: `wb_sel`=10, `pc_src`=10.
- `aluctr` by funct3 for OP/OP-IMM: 000 add (sub if OP and funct7[5]), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra by funct7[5], 110 or, 111 and.
- Branches: beq/bne → sub; blt/bge → slt; bltu/bgeu → sltu.
- All other opcodes → add. LUI uses `alua_src`=10, `alub_src`=01, `ext_op`=U. AUIPC uses `alua_src`=01.
- Taken: beq `zero`, bne !`zero`, blt/bltu `less`, bge/bgeu !`less`.
- Illegal when any of:
  - opcode is not one of the 9 RV32I base opcodes;
  - OP with funct7 ∉ {0x00, 0x20}, or 0x20 with funct3 ∉ {000, 101};
  - slli/srli with funct7≠0, or srai with funct7≠0x20;
  - load funct3 ∈ {011, 110, 111};
  - store funct3 > 010;
  - branch funct3 ∈ {010, 011};
  - jalr funct3≠0.
- HALT: `illegal`=1, no requests. Sticky until `rst`.

## Timing
- Reset: state=IDLE, IR=0x00000013, all outputs 0 immediately on `rst` assertion, even mid-transaction. First `imem_req` is in the 2nd cycle after release.
- Zero-wait-state latency (IF..final state):
  - OP/OP-IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each `mem_ready`-low cycle adds 1 cycle. The request stays asserted and stable throughout the wait.
- `mem_ready` high while no request is pending is ignored.
- `pc_we` and `reg_we` are each high exactly one cycle per instruction. `reg_we` is never asserted for rd-less instructions.

## Structure
- Shared package `ctrl_pkg`:
  - state enum;
  - `aluctr` codes;
  - RV32I opcode constants;
  - `pc_src`/`wb_sel`/`alua_src`/`alub_src`/`ext_op` encodings.
- Sub-module `alu_ctrl_dec` (combinational): opcode, funct3, funct7[5] → `aluctr`.
- FSM, IR register and illegal check live in the top module.

## Test plan
- `add` 0x002081B3, `mem_ready`=1 → states 1,2,3,5; `aluctr`=0000 in EX; `reg_we`, `pc_we` and `wb_sel`=00 only in WB.
- `sub` 0x402081B3 → `aluctr`=1000. `sra` 0x4020D1B3 → `aluctr`=1101.
- `lw` 0x0000A183, `mem_ready` low 2 cycles in MEM → `dmem_req` high 3 cycles, `dmem_we`=0, then WB with `wb_sel`=01.
- `beq` 0x00208463: `zero`=1 → EX `pc_we`=1, `pc_src`=01, `aluctr`=1000; `zero`=0 → `pc_src`=00. `bltu` 0x0020E463 → `aluctr`=0011.
- 0xFFFFFFFF fetched → HALT, `illegal`=1, no `imem_req` for 20 cycles.
- `rst` asserted mid-MEM of a store → `dmem_req`/`dmem_we` drop the same cycle, state=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the RV32I multi-cycle control unit
package ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
        S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6
    } state_t;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b1000, ALU_SLL = 4'b0001,
                           ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011, ALU_XOR = 4'b0100,
                           ALU_SRL = 4'b0101, ALU_SRA = 4'b1101, ALU_OR = 4'b0110,
                           ALU_AND = 4'b0111;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_I = 7'b0010011, OP_R = 7'b0110011;
    localparam logic [1:0] PC_4 = 2'b00, PC_IMM = 2'b01, PC_JALR = 2'b10;
    localparam logic [1:0] WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10;
    localparam logic [1:0] A_RS1 = 2'b00, A_PC = 2'b01, A_ZERO = 2'b10;
    localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01;
    localparam logic [2:0] EXT_I = 3'b000, EXT_U = 3'b001, EXT_S = 3'b010,
                           EXT_B = 3'b011, EXT_J = 3'b100;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: memory handshake, ALU flags and datapath controls
interface multicycle_ctrl_if;
    logic [31:0] instr;
    logic mem_ready, zero, less;
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, illegal;
    logic [1:0] pc_src, wb_sel, alua_src, alub_src;
    logic [2:0] ext_op, state;
    logic [3:0] aluctr;
    modport master (
        input instr, mem_ready, zero, less,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, wb_sel,
               alua_src, alub_src, ext_op, aluctr, illegal, state
    );
    modport slave (
        output instr, mem_ready, zero, less,
        input imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, wb_sel,
              alua_src, alub_src, ext_op, aluctr, illegal, state
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: opcode/funct3/funct7[5] to 4-bit ALU operation code
module alu_ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] aluctr
);
    // aluctr is {modifier, funct3} for OP/OP-IMM; OP-IMM never subtracts
    assign aluctr = opcode == OP_R      ? {funct7b5 & (funct3 == 3'b000 || funct3 == 3'b101), funct3} :
                    opcode == OP_I      ? {funct7b5 & (funct3 == 3'b101), funct3} :
                    opcode == OP_BRANCH ? (funct3[2:1] == 2'b00 ? ALU_SUB : funct3[1] ? ALU_SLTU : ALU_SLT) :
                    ALU_ADD;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EX/MEM/WB sequencer with IR register and illegal-instruction halt
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input logic clk,
    input logic rst,
    multicycle_ctrl_if.master bus
);
    state_t st;
    logic [31:0] ir;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] alu;
    logic bad, taken, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc, unused_ir;
    assign op = ir[6:0];
    assign f3 = ir[14:12];
    assign f7 = ir[31:25];
    assign unused_ir = ^{ir[24:15], ir[11:7]};
    assign is_ld = op == OP_LOAD;
    assign is_st = op == OP_STORE;
    assign is_br = op == OP_BRANCH;
    assign is_jal = op == OP_JAL;
    assign is_jalr = op == OP_JALR;
    assign is_lui = op == OP_LUI;
    assign is_auipc = op == OP_AUIPC;
    assign taken = f3[2:1] == 2'b00 ? bus.zero ^ f3[0] : bus.less ^ f3[0];
    alu_ctrl_dec u_dec (.opcode(op), .funct3(f3), .funct7b5(f7[5]), .aluctr(alu));
    always_comb begin
        bad = 1'b0;
        case (op)
            OP_R:      bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            OP_I:      bad = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
            OP_LOAD:   bad = f3 == 3'b011 || f3[2:1] == 2'b11;
            OP_STORE:  bad = f3 > 3'b010;
            OP_BRANCH: bad = f3[2:1] == 2'b01;
            OP_JALR:   bad = f3 != 3'b000;
            OP_LUI, OP_AUIPC, OP_JAL: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= S_IDLE;
            ir <= 32'h0000_0013;
        end else begin
            case (st)
                S_IDLE: st <= S_IF;
                S_IF: if (bus.mem_ready) begin
                    ir <= bus.instr;
                    st <= S_ID;
                end
                S_ID:   st <= bad ? S_HALT : S_EX;
                S_EX:   st <= is_br ? S_IF : (is_ld || is_st) ? S_MEM : S_WB;
                S_MEM:  if (bus.mem_ready) st <= is_ld ? S_WB : S_IF;
                S_WB:   st <= S_IF;
                S_HALT: st <= S_HALT;
                default: st <= S_IDLE;
            endcase
        end
    end
    // outputs decode straight from state/IR so an async reset clears them at once
    always_comb begin
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we = 1'b0;
        bus.ir_we = 1'b0;
        bus.pc_we = 1'b0;
        bus.pc_src = PC_4;
        bus.reg_we = 1'b0;
        bus.wb_sel = WB_ALU;
        bus.alua_src = A_RS1;
        bus.alub_src = B_RS2;
        bus.ext_op = EXT_I;
        bus.aluctr = ALU_ADD;
        bus.illegal = 1'b0;
        bus.state = st;
        case (st)
            S_IF: begin
                bus.imem_req = 1'b1;
                bus.ir_we = bus.mem_ready;
            end
            S_EX: begin
                bus.aluctr = alu;
                bus.alua_src = is_lui ? A_ZERO : is_auipc ? A_PC : A_RS1;
                bus.alub_src = (op == OP_R || is_br) ? B_RS2 : B_IMM;
                bus.ext_op = (is_lui || is_auipc) ? EXT_U : is_st ? EXT_S : is_br ? EXT_B : is_jal ? EXT_J : EXT_I;
                bus.pc_we = is_br;
                bus.pc_src = (is_br && taken) ? PC_IMM : PC_4;
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we = is_st;
                bus.pc_we = is_st && bus.mem_ready;
            end
            S_WB: begin
                bus.reg_we = 1'b1;
                bus.pc_we = 1'b1;
                bus.wb_sel = is_ld ? WB_MEM : (is_jal || is_jalr) ? WB_PC4 : WB_ALU;
                bus.pc_src = is_jal ? PC_IMM : is_jalr ? PC_JALR : PC_4;
            end
            S_HALT: bus.illegal = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences with a per-cycle expected-output scoreboard
module tb_multicycle_ctrl;
    typedef struct packed {
        logic [2:0] st;
        logic imem, dmem, dwe, irwe, pcwe;
        logic [1:0] pcs;
        logic regwe;
        logic [1:0] wbs, aa, ab;
        logic [2:0] ext;
        logic [3:0] alu;
        logic ill;
    } obs_t;
    logic clk = 1'b0, rst = 1'b1;
    multicycle_ctrl_if bus ();
    multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));
    always #5 clk = ~clk;
    obs_t exp_q[$];
    string nm_q[$];
    int checks = 0, passed = 0;
    function automatic obs_t e(input logic [2:0] st);
        e = '0;
        e.st = st;
    endfunction
    initial begin
        obs_t got, want;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                nm = nm_q.pop_front();
                got = {bus.state, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_we, bus.pc_we,
                       bus.pc_src, bus.reg_we, bus.wb_sel, bus.alua_src, bus.alub_src,
                       bus.ext_op, bus.aluctr, bus.illegal};
                checks++;
                if (got == want) passed++;
                else $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", nm, got, got.st, want, want.st);
            end
        end
    end
    task automatic step(input logic r, mr, z, l, input obs_t x, input string nm);
        @(posedge clk);
        #1;
        rst = r;
        bus.mem_ready = mr;
        bus.zero = z;
        bus.less = l;
        exp_q.push_back(x);
        nm_q.push_back(nm);
    endtask
    task automatic fetch(input logic [31:0] ins, input int waits, input string nm);
        obs_t x;
        x = e(3'd1);
        x.imem = 1'b1;
        bus.instr = 32'h0000_0000;
        for (int i = 0; i < waits; i++) step(0, 0, 0, 0, x, {nm, " if-wait"});
        bus.instr = ins;
        x.irwe = 1'b1;
        step(0, 1, 0, 0, x, {nm, " if"});
        step(0, 1, 0, 0, e(3'd2), {nm, " id"});
    endtask
    task automatic run_wb(input logic [31:0] ins, input logic [3:0] al, input logic [1:0] aa, ab,
                          input logic [2:0] ext, input logic [1:0] wbs, pcs, input string nm);
        obs_t x;
        fetch(ins, 0, nm);
        x = e(3'd3);
        x.alu = al; x.aa = aa; x.ab = ab; x.ext = ext;
        step(0, 0, 0, 0, x, {nm, " ex"});
        x = e(3'd5);
        x.regwe = 1'b1; x.pcwe = 1'b1; x.wbs = wbs; x.pcs = pcs;
        step(0, 0, 0, 0, x, {nm, " wb"});
    endtask
    task automatic run_br(input logic [31:0] ins, input logic z, l, input logic [3:0] al,
                          input logic [1:0] pcs, input string nm);
        obs_t x;
        fetch(ins, 0, nm);
        x = e(3'd3);
        x.alu = al; x.ext = 3'b011; x.pcwe = 1'b1; x.pcs = pcs;
        step(0, 0, z, l, x, {nm, " ex"});
    endtask
    initial begin
        obs_t x;
        bus.instr = '0; bus.mem_ready = 1'b0; bus.zero = 1'b0; bus.less = 1'b0;
        step(1, 0, 0, 0, e(3'd0), "reset");
        step(0, 1, 0, 0, e(3'd0), "idle after release");
        // add with one instruction-memory wait state
        x = e(3'd1); x.imem = 1'b1;
        step(0, 0, 0, 0, x, "add if-wait");
        x.irwe = 1'b1; bus.instr = 32'h0020_81B3;
        step(0, 1, 0, 0, x, "add if");
        step(0, 1, 0, 0, e(3'd2), "add id");
        step(0, 0, 0, 0, e(3'd3), "add ex");
        x = e(3'd5); x.regwe = 1'b1; x.pcwe = 1'b1;
        step(0, 0, 0, 0, x, "add wb");
        run_wb(32'h4020_81B3, 4'b1000, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, "sub");
        run_wb(32'h4020_D1B3, 4'b1101, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, "sra");
        run_wb(32'h0050_8193, 4'b0000, 2'b00, 2'b01, 3'b000, 2'b00, 2'b00, "addi");
        run_wb(32'h4050_D193, 4'b1101, 2'b00, 2'b01, 3'b000, 2'b00, 2'b00, "srai");
        run_wb(32'h1234_51B7, 4'b0000, 2'b10, 2'b01, 3'b001, 2'b00, 2'b00, "lui");
        run_wb(32'h1234_5197, 4'b0000, 2'b01, 2'b01, 3'b001, 2'b00, 2'b00, "auipc");
        run_wb(32'h0080_01EF, 4'b0000, 2'b00, 2'b01, 3'b100, 2'b10, 2'b01, "jal");
        run_wb(32'h0000_81E7, 4'b0000, 2'b00, 2'b01, 3'b000, 2'b10, 2'b10, "jalr");
        // lw with two data-memory wait states
        fetch(32'h0000_A183, 0, "lw");
        x = e(3'd3); x.ab = 2'b01;
        step(0, 0, 0, 0, x, "lw ex");
        x = e(3'd4); x.dmem = 1'b1;
        step(0, 0, 0, 0, x, "lw mem-wait1");
        step(0, 0, 0, 0, x, "lw mem-wait2");
        step(0, 1, 0, 0, x, "lw mem");
        x = e(3'd5); x.regwe = 1'b1; x.pcwe = 1'b1; x.wbs = 2'b01;
        step(0, 0, 0, 0, x, "lw wb");
        // sw zero-wait
        fetch(32'h0020_A023, 0, "sw");
        x = e(3'd3); x.ab = 2'b01; x.ext = 3'b010;
        step(0, 0, 0, 0, x, "sw ex");
        x = e(3'd4); x.dmem = 1'b1; x.dwe = 1'b1; x.pcwe = 1'b1;
        step(0, 1, 0, 0, x, "sw mem");
        run_br(32'h0020_8463, 1, 0, 4'b1000, 2'b01, "beq taken");
        run_br(32'h0020_8463, 0, 0, 4'b1000, 2'b00, "beq not taken");
        run_br(32'h0020_E463, 0, 1, 4'b0011, 2'b01, "bltu taken");
        run_br(32'h0020_D463, 0, 1, 4'b0010, 2'b00, "bge not taken");
        // asynchronous reset in the middle of a stalled store
        fetch(32'h0020_A023, 0, "sw2");
        x = e(3'd3); x.ab = 2'b01; x.ext = 3'b010;
        step(0, 0, 0, 0, x, "sw2 ex");
        x = e(3'd4); x.dmem = 1'b1; x.dwe = 1'b1;
        step(0, 0, 0, 0, x, "sw2 mem-wait");
        step(1, 0, 0, 0, e(3'd0), "rst mid-mem");
        step(0, 0, 0, 0, e(3'd0), "idle after mid-mem rst");
        // OP with funct7=0x01 halts; reset recovers
        fetch(32'h0220_81B3, 0, "op f7=01");
        x = e(3'd6); x.ill = 1'b1;
        step(0, 1, 0, 0, x, "op f7=01 halt");
        step(0, 1, 0, 0, x, "op f7=01 halt sticky");
        step(1, 0, 0, 0, e(3'd0), "rst from halt");
        step(0, 0, 0, 0, e(3'd0), "idle after halt rst");
        fetch(32'hFFFF_FFFF, 0, "all-ones");
        for (int i = 0; i < 21; i++) step(0, 1, 0, 0, x, "all-ones halt");
        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
